exception_ctrl: RTL
===================

Name: exception_ctrl

Overview:
- Commit-stage exception arbiter for the dual-issue pipeline; the write-side driver of the CP0 register block's exception interface.
- Reads CP0 status/cause/epc/ebase, selects the highest-priority event from the two MEM-stage slots, and waits for outstanding data-bus traffic to drain.
- Then issues a one-cycle registered exception commit to CP0, together with pipeline flush and redirect PC.

Parameters:
- EXC_OFFSET, 32'h0000_0180, offset added to ebase for the general exception vector.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- valid1_i / valid2_i  in  1 each  slot1/slot2 hold a real instruction (slot1 is older).
- excp1_i / excp2_i  in  9 each  per-slot cause bits: [0] fetch AdEL, [1] RI, [2] SYS, [3] BP, [4] OV, [5] TR, [6] data AdEL, [7] AdES, [8] ERET.
- inst1_addr_i / inst2_addr_i  in  32 each  slot PCs.
- ds1_i / ds2_i  in  1 each  slot is in a delay slot.
- mem_addr_i  in  32  data virtual address of the memory slot.
- dbus_busy_i  in  1  data request outstanding.
- status_i / cause_i / epc_i / ebase_i  in  32 each  CP0 register outputs.
- exception_flag_o  out  1  to CP0.
- exception_type_o  out  5  to CP0.
- exception_first_inst_o  out  1  to CP0.
- inst1_addr_o / inst2_addr_o / mem_addr_o  out  32 each  latched, to CP0.
- ds1_o / ds2_o  out  1 each  latched, to CP0.
- stall_o  out  1  freeze IF..MEM.
- flush_o  out  1  kill all in-flight instructions.
- new_pc_o  out  32  redirect target, valid when flush_o=1.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE. Reset mid-DRAIN or mid-COMMIT aborts immediately; no exception is committed.
- ExcCodes: INT 5'h00, AdEL 5'h04, AdES 5'h05, SYS 5'h08, BP 5'h09, RI 5'h0a, OV 5'h0c, TR 5'h0d, ERET 5'h0e.
- Interrupt pending = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]). It attaches to slot1 if valid1_i, else to slot2 if valid2_i; if neither slot is valid, no interrupt is taken.
- Per-slot priority, high to low: INT, fetch AdEL, RI, SYS, BP, OV, TR, data AdEL, AdES, ERET. Bits of an invalid slot are ignored.
- Slot1 event wins over any slot2 event. exception_first_inst_o=1 iff the chosen event is in slot1.
- mem_addr_o takes mem_addr_i only for data AdEL/AdES, otherwise 0. Fetch AdEL sets mem_addr_o to the faulting PC.
- FSM IDLE: an event is detected in cycle N.
  - If dbus_busy_i=0: latch type, slot, addrs and ds flags; go to COMMIT.
  - If dbus_busy_i=1: latch the same, assert stall_o, go to DRAIN.
- FSM DRAIN: stall_o=1; stay while dbus_busy_i=1, go to COMMIT on the first cycle it is 0. New events are ignored while in DRAIN.
- FSM COMMIT (exactly 1 cycle): exception_flag_o=1, flush_o=1, stall_o=0; all latched outputs are valid.
  - new_pc_o = epc_i sampled this cycle for ERET, else ebase_i + EXC_OFFSET (32-bit wrap).
  - Next state is RECOVER.
- FSM RECOVER (1 cycle): all flags 0; inputs masked so the flushed bundle is not re-detected; go to IDLE.
- Best case: event in cycle N -> flag/flush in N+1; next event detectable no earlier than N+3.
- exception_type_o and latched addresses hold their values outside COMMIT. CP0 qualifies them only with exception_flag_o.

Test Plan:
- Slot1 valid, excp1_i=9'h004 (SYS) at 0xBFC0_0100, ds1=0, ebase=0xBFC0_0200, busy=0 -> next cycle: flag=1, type=5'h08, first=1, new_pc=0xBFC0_0380, flush=1 for one cycle only.
- Slot1 clean, slot2 excp2_i=9'h080 (AdES), mem_addr=0x8000_0003, busy=1 for 3 cycles -> stall_o high 3 cycles, then COMMIT with type=5'h05, first=0, mem_addr_o=0x8000_0003.
- status=0x0000_0401, cause[10]=1, slot1 has OV -> type=5'h00 (INT beats OV), first=1. Repeat with status[1]=1 -> type=5'h0c.
- Slot2 only valid with excp2_i=9'h100 (ERET), epc=0x8000_1234 -> type=5'h0e, new_pc=0x8000_1234.
- Event held constant across COMMIT -> exactly one flag pulse, none in the RECOVER cycle.
- Assert rst low during DRAIN -> all outputs 0 asynchronously; no flag after release.

Source files
------------

// File: rtl/exception_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exception_ctrl_if : pipeline/CP0 signal bundle for exception_ctrl  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface exception_ctrl_if;
  logic        valid1_i;
  logic        valid2_i;
  logic [8:0]  excp1_i;
  logic [8:0]  excp2_i;
  logic [31:0] inst1_addr_i;
  logic [31:0] inst2_addr_i;
  logic        ds1_i;
  logic        ds2_i;
  logic [31:0] mem_addr_i;
  logic        dbus_busy_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] ebase_i;
  logic        exception_flag_o;
  logic [4:0]  exception_type_o;
  logic        exception_first_inst_o;
  logic [31:0] inst1_addr_o;
  logic [31:0] inst2_addr_o;
  logic [31:0] mem_addr_o;
  logic        ds1_o;
  logic        ds2_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    input  valid1_i, valid2_i, excp1_i, excp2_i, inst1_addr_i, inst2_addr_i,
           ds1_i, ds2_i, mem_addr_i, dbus_busy_i, status_i, cause_i, epc_i, ebase_i,
    output exception_flag_o, exception_type_o, exception_first_inst_o,
           inst1_addr_o, inst2_addr_o, mem_addr_o, ds1_o, ds2_o,
           stall_o, flush_o, new_pc_o
  );

  modport slave (
    output valid1_i, valid2_i, excp1_i, excp2_i, inst1_addr_i, inst2_addr_i,
           ds1_i, ds2_i, mem_addr_i, dbus_busy_i, status_i, cause_i, epc_i, ebase_i,
    input  exception_flag_o, exception_type_o, exception_first_inst_o,
           inst1_addr_o, inst2_addr_o, mem_addr_o, ds1_o, ds2_o,
           stall_o, flush_o, new_pc_o
  );
endinterface
`default_nettype wire

// File: rtl/exception_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exception_ctrl : commit-stage exception arbiter driving CP0        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module exception_ctrl #(
  parameter logic [31:0] EXC_OFFSET = 32'h0000_0180
) (
  input  wire logic        clk,
  input  wire logic        rst,
  exception_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_COMMIT  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  type_q, type_d;
  logic        first_q, first_d;
  logic [31:0] inst1_q, inst1_d;
  logic [31:0] inst2_q, inst2_d;
  logic [31:0] maddr_q, maddr_d;
  logic        ds1_q, ds1_d;
  logic        ds2_q, ds2_d;

  logic        w_int_pend, w_int1, w_int2, w_has1, w_has2, w_sel_int;
  logic [8:0]  w_exc1, w_exc2, w_sel_exc;
  logic [31:0] w_sel_pc, w_sel_maddr;
  logic [4:0]  w_code;
  logic        w_unused;

  assign w_unused = ^{bus.status_i[31:16], bus.status_i[7:2],
                      bus.cause_i[31:16], bus.cause_i[7:0]};

  // Event selection: slot1 is older, so any slot1 event wins.
  always_comb begin
    w_int_pend = bus.status_i[0] & ~bus.status_i[1] &
                 (|(bus.cause_i[15:8] & bus.status_i[15:8]));
    w_exc1     = bus.valid1_i ? bus.excp1_i : 9'h000;
    w_exc2     = bus.valid2_i ? bus.excp2_i : 9'h000;
    w_int1     = w_int_pend & bus.valid1_i;
    w_int2     = w_int_pend & ~bus.valid1_i & bus.valid2_i;
    w_has1     = w_int1 | (|w_exc1);
    w_has2     = w_int2 | (|w_exc2);
    w_sel_int  = w_has1 ? w_int1 : w_int2;
    w_sel_exc  = w_has1 ? w_exc1 : w_exc2;
    w_sel_pc   = w_has1 ? bus.inst1_addr_i : bus.inst2_addr_i;

    w_code      = 5'h00;
    w_sel_maddr = 32'h0000_0000;
    if (w_sel_int)         w_code = 5'h00;
    else if (w_sel_exc[0]) begin
      w_code      = 5'h04;
      w_sel_maddr = w_sel_pc;
    end
    else if (w_sel_exc[1]) w_code = 5'h0a;
    else if (w_sel_exc[2]) w_code = 5'h08;
    else if (w_sel_exc[3]) w_code = 5'h09;
    else if (w_sel_exc[4]) w_code = 5'h0c;
    else if (w_sel_exc[5]) w_code = 5'h0d;
    else if (w_sel_exc[6]) begin
      w_code      = 5'h04;
      w_sel_maddr = bus.mem_addr_i;
    end
    else if (w_sel_exc[7]) begin
      w_code      = 5'h05;
      w_sel_maddr = bus.mem_addr_i;
    end
    else if (w_sel_exc[8]) w_code = 5'h0e;
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    first_d = first_q;
    inst1_d = inst1_q;
    inst2_d = inst2_q;
    maddr_d = maddr_q;
    ds1_d   = ds1_q;
    ds2_d   = ds2_q;
    case (state_q)
      S_IDLE: begin
        if (w_has1 | w_has2) begin
          type_d  = w_code;
          first_d = w_has1;
          inst1_d = bus.inst1_addr_i;
          inst2_d = bus.inst2_addr_i;
          maddr_d = w_sel_maddr;
          ds1_d   = bus.ds1_i;
          ds2_d   = bus.ds2_i;
          state_d = bus.dbus_busy_i ? S_DRAIN : S_COMMIT;
        end
      end
      S_DRAIN:   if (!bus.dbus_busy_i) state_d = S_COMMIT;
      S_COMMIT:  state_d = S_RECOVER;
      // The flushed bundle may still sit on the inputs; skip one cycle.
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      type_q  <= 5'h00;
      first_q <= 1'b0;
      inst1_q <= 32'h0;
      inst2_q <= 32'h0;
      maddr_q <= 32'h0;
      ds1_q   <= 1'b0;
      ds2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      first_q <= first_d;
      inst1_q <= inst1_d;
      inst2_q <= inst2_d;
      maddr_q <= maddr_d;
      ds1_q   <= ds1_d;
      ds2_q   <= ds2_d;
    end
  end

  assign bus.exception_flag_o       = (state_q == S_COMMIT);
  assign bus.flush_o                = (state_q == S_COMMIT);
  assign bus.stall_o                = (state_q == S_DRAIN);
  assign bus.exception_type_o       = type_q;
  assign bus.exception_first_inst_o = first_q;
  assign bus.inst1_addr_o           = inst1_q;
  assign bus.inst2_addr_o           = inst2_q;
  assign bus.mem_addr_o             = maddr_q;
  assign bus.ds1_o                  = ds1_q;
  assign bus.ds2_o                  = ds2_q;
  assign bus.new_pc_o = (state_q != S_COMMIT) ? 32'h0 :
                        (type_q == 5'h0e)     ? bus.epc_i :
                                                bus.ebase_i + EXC_OFFSET;

endmodule
`default_nettype wire
